scan_decoder: RTL

Parametrised, registered N-to-2^N one-hot decoder with an enable, plus built-in scan and single-sweep sequencing. It is the next-generation replacement for the fixed 4-to-16 decoder stages and drives multiplexed displays, LED matrices and row strobes. In direct mode it decodes an external select; in scan and sweep modes an internal counter walks the outputs with a programmable dwell.

---
 rtl/scan_decoder_if.sv | 24 ++
 rtl/scan_decoder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/scan_decoder_if.sv
// Select/control and decoded-output bundle for scan_decoder.
// master drives select and control; slave (the decoder) drives outputs.
interface scan_decoder_if #(
   parameter int N = 4
) ();
   logic [N-1:0]      w;
   logic              e;
   logic [1:0]        mode;
   logic              start;
   logic [(1<<N)-1:0] y;
   logic [N-1:0]      idx;
   logic              busy;
   logic              done;

   modport master (
      output w, e, mode, start,
      input  y, idx, busy, done
   );

   modport slave (
      input  w, e, mode, start,
      output y, idx, busy, done
   );
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with direct, scan, single-sweep and hold modes.
// Define SCAN_DECODER_ACTIVE_LOW_EN to drive y inverted (common-anode displays).
module scan_decoder #(
   parameter int N     = 4,
   parameter int DWELL = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   scan_decoder_if.slave bus
);
   localparam int W  = 1 << N;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
   localparam logic [N-1:0]  IDX_LAST = '1;
   localparam logic [W-1:0]  ONE      = W'(1);

   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_SCAN   = 2'b01;
   localparam logic [1:0] MODE_SWEEP  = 2'b10;

   typedef enum logic [2:0] {
      ST_DIRECT,
      ST_SCAN,
      ST_SWEEP_IDLE,
      ST_SWEEP_RUN,
      ST_HOLD
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_y;
   logic [N-1:0]  r_idx;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;
   logic          r_lit;

   logic          w_cnt_last;
   logic [N-1:0]  w_step_idx;
   logic [CW-1:0] w_step_cnt;
   logic [W-1:0]  w_dec_w;
   logic [W-1:0]  w_dec_step;
   logic [W-1:0]  w_dec_idx;

   // One dwell step: advance idx when the current index has been shown DWELL cycles.
   assign w_cnt_last = (r_cnt == CNT_LAST);
   assign w_step_idx = w_cnt_last ? r_idx + 1'b1 : r_idx;
   assign w_step_cnt = w_cnt_last ? '0 : r_cnt + 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_dec
         assign w_dec_w[gi]    = (bus.w == N'(gi));
         assign w_dec_step[gi] = (w_step_idx == N'(gi));
         assign w_dec_idx[gi]  = (r_idx == N'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_DIRECT;
         r_y     <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_lit   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (bus.mode)
            MODE_DIRECT: begin
               r_state <= ST_DIRECT;
               r_y     <= bus.e ? w_dec_w : '0;
               r_idx   <= bus.w;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end

            MODE_SCAN: begin
               r_state <= ST_SCAN;
               r_busy  <= 1'b0;
               if (r_state == ST_SCAN || r_state == ST_HOLD) begin
                  if (bus.e) begin
                     r_idx <= w_step_idx;
                     r_cnt <= w_step_cnt;
                     r_y   <= w_dec_step;
                  end else begin
                     r_y <= '0;
                  end
               end else begin
                  r_idx <= '0;
                  r_cnt <= '0;
                  r_y   <= bus.e ? ONE : '0;
               end
            end

            MODE_SWEEP: begin
               // A sweep paused in HOLD resumes where it stopped.
               if (r_state == ST_SWEEP_RUN || (r_state == ST_HOLD && r_busy)) begin
                  r_state <= ST_SWEEP_RUN;
                  if (!bus.e) begin
                     r_y <= '0;
                  end else if (w_cnt_last && r_idx == IDX_LAST) begin
                     r_state <= ST_SWEEP_IDLE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_y     <= '0;
                     r_idx   <= '0;
                     r_cnt   <= '0;
                  end else begin
                     r_idx <= w_step_idx;
                     r_cnt <= w_step_cnt;
                     r_y   <= w_dec_step;
                  end
               end else if (r_state == ST_SWEEP_IDLE) begin
                  if (bus.start) begin
                     r_state <= ST_SWEEP_RUN;
                     r_busy  <= 1'b1;
                     r_idx   <= '0;
                     r_cnt   <= '0;
                     r_y     <= bus.e ? ONE : '0;
                  end
               end else begin
                  r_state <= ST_SWEEP_IDLE;
                  r_busy  <= 1'b0;
                  r_idx   <= '0;
                  r_cnt   <= '0;
                  r_y     <= '0;
               end
            end

            default: begin
               // r_lit remembers whether an index was lit on entry, so e can blank and restore it.
               r_state <= ST_HOLD;
               if (r_state != ST_HOLD) begin
                  r_lit <= |r_y;
                  r_y   <= bus.e ? r_y : '0;
               end else begin
                  r_y <= (bus.e && r_lit) ? w_dec_idx : '0;
               end
            end
         endcase
      end
   end

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
   assign bus.y = ~r_y;
`else
   assign bus.y = r_y;
`endif
   assign bus.idx  = r_idx;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule
